// File: rtl/data_sram_if.sv
// rtl/data_sram_if.sv - data-RAM request/response bus between execute/memory stages and the RAM
interface data_sram_if;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wen,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wen,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - byte-writable data RAM answering each accepted request after a fixed latency
module data_sram_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2,
    parameter int QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_in,
    data_sram_if.slave  bus,
    output logic [2:0]  pending_cnt
);
    localparam int              PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [2:0]      CNT_INIT = 3'(LATENCY - 1);
    localparam logic [2:0]      QDEPTH_C = 3'(QDEPTH);
    localparam logic [PW-1:0]   PTR_LAST = PW'(QDEPTH - 1);

    logic [31:0]          mem     [2**ADDR_BITS];
    logic [31:0]          q_rdata [QDEPTH];
    logic [2:0]           q_cnt   [QDEPTH];
    logic [QDEPTH-1:0]    q_valid;
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;

    logic [ADDR_BITS-1:0] word_idx;
    logic                 is_write;
    logic                 push;
    logic                 pop_now;
    logic                 unused_addr_bits;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign word_idx         = bus.data_addr[ADDR_BITS+1:2];
    assign unused_addr_bits = ^{bus.data_addr[31:ADDR_BITS+2], bus.data_addr[1:0]};
    assign is_write         = |bus.data_wen;

    // Head entry whose countdown expired answers this cycle and frees its slot at the edge.
    assign pop_now = q_valid[head] && (q_cnt[head] == 3'd0);

    // Depends only on registered state and stall_in so the requester's stop logic cannot loop through it.
    assign bus.data_addr_ok = ~stall_in & ((pending_cnt < QDEPTH_C) | pop_now);
    assign push             = bus.data_req & bus.data_addr_ok;

    assign bus.data_data_ok = pop_now;
    assign bus.data_rdata   = pop_now ? q_rdata[head] : 32'd0;

    // Memory survives reset; writes only take effect on a real acceptance.
    always_ff @(posedge clk) begin
        if (resetn && push && is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_wen[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.data_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_valid     <= '0;
            head        <= '0;
            tail        <= '0;
            pending_cnt <= 3'd0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (q_valid[i] && (q_cnt[i] != 3'd0)) begin
                    q_cnt[i] <= q_cnt[i] - 3'd1;
                end
            end

            if (pop_now) begin
                q_valid[head] <= 1'b0;
                head          <= next_ptr(head);
            end

            // Placed after the pop so a push into the slot being freed (full queue) wins.
            if (push) begin
                q_valid[tail] <= 1'b1;
                q_cnt[tail]   <= CNT_INIT;
                q_rdata[tail] <= is_write ? 32'd0 : mem[word_idx];
                tail          <= next_ptr(tail);
            end

            if (push && !pop_now) begin
                pending_cnt <= pending_cnt + 3'd1;
            end else if (!push && pop_now) begin
                pending_cnt <= pending_cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder at latency 2 and 4
module tb_data_sram_responder;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       stall2 = 1'b0;
    logic       stall4 = 1'b0;
    logic [2:0] pend2;
    logic [2:0] pend4;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb2[$];
    exp_t        sb4[$];
    logic [31:0] mdl[int];

    data_sram_if b2 ();
    data_sram_if b4 ();

    data_sram_responder #(.ADDR_BITS(10), .LATENCY(2), .QDEPTH(2)) dut2 (
        .clk(clk), .resetn(resetn), .stall_in(stall2), .bus(b2.slave), .pending_cnt(pend2));

    data_sram_responder #(.ADDR_BITS(10), .LATENCY(4), .QDEPTH(2)) dut4 (
        .clk(clk), .resetn(resetn), .stall_in(stall4), .bus(b4.slave), .pending_cnt(pend4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_accept(input int inst, input logic [3:0] wen,
                                                 input logic [31:0] addr, input logic [31:0] wdata);
        int          key;
        logic [31:0] cur;
        key = (inst << 16) | int'(addr[11:2]);
        cur = mdl.exists(key) ? mdl[key] : 32'd0;
        if (wen == 4'd0) return cur;
        for (int i = 0; i < 4; i++) if (wen[i]) cur[8*i +: 8] = wdata[8*i +: 8];
        mdl[key] = cur;
        return 32'd0;
    endfunction

    // Response checking first, then record any acceptance happening at the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (b2.data_data_ok) begin
            if (sb2.size() == 0) check("l2_unexpected_data_ok", 32'd1, 32'd0);
            else begin
                e = sb2.pop_front();
                check("l2_rdata", b2.data_rdata, e.data);
                check("l2_resp_cycle", cyc, e.due);
            end
        end
        if (b4.data_data_ok) begin
            if (sb4.size() == 0) check("l4_unexpected_data_ok", 32'd1, 32'd0);
            else begin
                e = sb4.pop_front();
                check("l4_rdata", b4.data_rdata, e.data);
                check("l4_resp_cycle", cyc, e.due);
            end
        end
        if (resetn && b2.data_req && b2.data_addr_ok) begin
            e.data = model_accept(2, b2.data_wen, b2.data_addr, b2.data_wdata);
            e.due  = cyc + 2;
            sb2.push_back(e);
        end
        if (resetn && b4.data_req && b4.data_addr_ok) begin
            e.data = model_accept(4, b4.data_wen, b4.data_addr, b4.data_wdata);
            e.due  = cyc + 4;
            sb4.push_back(e);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set2(input logic req, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        b2.data_req = req; b2.data_wen = wen; b2.data_addr = addr; b2.data_wdata = wdata;
    endtask

    task automatic set4(input logic req, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        b4.data_req = req; b4.data_wen = wen; b4.data_addr = addr; b4.data_wdata = wdata;
    endtask

    initial begin
        set2(1'b0, 4'd0, 32'd0, 32'd0);
        set4(1'b0, 4'd0, 32'd0, 32'd0);
        nxt(); nxt();
        @(negedge clk);
        check("reset_pending", 32'(pend2), 32'd0);
        check("reset_data_ok", 32'(b2.data_data_ok), 32'd0);
        check("reset_rdata", b2.data_rdata, 32'd0);
        check("reset_addr_ok", 32'(b2.data_addr_ok), 32'd1);
        nxt();
        resetn = 1'b1;
        nxt();

        // store then load of the same word on back-to-back cycles
        set2(1'b1, 4'hF, 32'h10, 32'h12345678);
        @(negedge clk); check("sw_addr_ok", 32'(b2.data_addr_ok), 32'd1);
        nxt();
        set2(1'b1, 4'h0, 32'h10, 32'h0);
        @(negedge clk); check("lw_addr_ok", 32'(b2.data_addr_ok), 32'd1);
        nxt();
        set2(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk); check("sw_ok_pulse", 32'(b2.data_data_ok), 32'd1);
        nxt();
        @(negedge clk); check("lw_value", b2.data_rdata, 32'h12345678);
        repeat (3) nxt();

        // byte-lane merge: expected 0xAAEECCDD
        set2(1'b1, 4'hF, 32'h20, 32'hAABBCCDD); nxt();
        set2(1'b1, 4'b0100, 32'h20, 32'h00EE0000); nxt();
        set2(1'b1, 4'h0, 32'h20, 32'h0); nxt();
        set2(1'b0, 4'h0, 32'h0, 32'h0);
        nxt();
        @(negedge clk); check("byte_merge", b2.data_rdata, 32'hAAEECCDD);
        repeat (3) nxt();

        // request held every cycle: overlap of push and pop at full occupancy
        for (int i = 0; i < 8; i++) begin
            set2(1'b1, (i < 4) ? 4'hF : 4'h0, 32'h40 + 32'(4 * (i % 4)), $urandom);
            @(negedge clk);
            check("b2b_addr_ok", 32'(b2.data_addr_ok), 32'd1);
            if (i >= 2) begin
                check("b2b_pending", 32'(pend2), 32'd2);
                check("b2b_data_ok", 32'(b2.data_data_ok), 32'd1);
            end
            nxt();
        end
        set2(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (4) nxt();

        // backpressure with a read still in flight
        set2(1'b1, 4'h0, 32'h44, 32'h0); nxt();
        stall2 = 1'b1;
        set2(1'b1, 4'h0, 32'h48, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_addr_ok", 32'(b2.data_addr_ok), 32'd0);
            nxt();
        end
        stall2 = 1'b0;
        @(negedge clk); check("unstall_addr_ok", 32'(b2.data_addr_ok), 32'd1);
        nxt();
        set2(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (4) nxt();

        // latency 4: queue fills and reopens on the first response
        set4(1'b1, 4'hF, 32'h0, 32'hDEADBEEF); nxt();
        set4(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (5) nxt();
        set4(1'b1, 4'h0, 32'h0, 32'h0);
        @(negedge clk); check("full_acc0", 32'(b4.data_addr_ok), 32'd1); nxt();
        @(negedge clk); check("full_acc1", 32'(b4.data_addr_ok), 32'd1); nxt();
        @(negedge clk); check("full_block0", 32'(b4.data_addr_ok), 32'd0);
        check("full_pending", 32'(pend4), 32'd2); nxt();
        @(negedge clk); check("full_block1", 32'(b4.data_addr_ok), 32'd0); nxt();
        @(negedge clk); check("full_reopen", 32'(b4.data_addr_ok), 32'd1);
        check("full_pop_data_ok", 32'(b4.data_data_ok), 32'd1); nxt();
        set4(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (7) nxt();

        // reset with a read in flight
        set2(1'b1, 4'hF, 32'h50, 32'hCAFEF00D); nxt();
        set2(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) nxt();
        set2(1'b1, 4'h0, 32'h50, 32'h0);
        @(negedge clk); check("rst_read_addr_ok", 32'(b2.data_addr_ok), 32'd1); nxt();
        set2(1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        @(negedge clk);
        sb2.delete();
        sb4.delete();
        nxt();
        resetn = 1'b1;
        @(negedge clk); check("rst_mid_pending", 32'(pend2), 32'd0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            @(negedge clk); check("rst_mid_no_pulse", 32'(b2.data_data_ok), 32'd0);
        end
        nxt();
        set2(1'b1, 4'h0, 32'h50, 32'h0); nxt();
        set2(1'b0, 4'h0, 32'h0, 32'h0);
        nxt();
        @(negedge clk); check("rst_mem_kept", b2.data_rdata, 32'hCAFEF00D);
        repeat (6) nxt();

        check("l2_sb_drained", 32'(sb2.size()), 32'd0);
        check("l4_sb_drained", 32'(sb4.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
